// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//
// Ports
//   clk, reset                 clock and asynchronous active-high reset
//   reqN_valid / reqN_ready    request handshake for port N (0/1)
//   reqN_op, reqN_lhs, reqN_rhs operation code and operands for port N
//   rspN_valid / rspN_ready    response handshake for port N
//   rspN_res                   registered result (shared register, qualified by rspN_valid)
//   ops_count                  completed response handshakes, wraps
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no result held
// RESP  | res_q holds a valid result for port owner_q
module alu_arbiter #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_op,
   input  logic [XLEN-1:0]  req0_lhs,
   input  logic [XLEN-1:0]  req0_rhs,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [XLEN-1:0]  rsp0_res,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_op,
   input  logic [XLEN-1:0]  req1_lhs,
   input  logic [XLEN-1:0]  req1_rhs,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [XLEN-1:0]  rsp1_res,
   output logic [CNT_W-1:0] ops_count
);

   localparam logic [3:0] ALU_OP_ADD  = 4'h0;
   localparam logic [3:0] ALU_OP_SUB  = 4'h1;
   localparam logic [3:0] ALU_OP_SLL  = 4'h2;
   localparam logic [3:0] ALU_OP_SLT  = 4'h3;
   localparam logic [3:0] ALU_OP_SLTU = 4'h4;
   localparam logic [3:0] ALU_OP_XOR  = 4'h5;
   localparam logic [3:0] ALU_OP_SRL  = 4'h6;
   localparam logic [3:0] ALU_OP_SRA  = 4'h7;
   localparam logic [3:0] ALU_OP_OR   = 4'h8;
   localparam logic [3:0] ALU_OP_AND  = 4'h9;

   localparam int               SH_W     = $clog2(XLEN);
   localparam logic [XLEN-1:0]  ALU_DFLT = 'hA;
   localparam logic [CNT_W-1:0] CNT_ONE  = 1;

   typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

   state_t            state_q, state_d;
   logic              owner_q, last_grant_q;
   logic [XLEN-1:0]   res_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              owner_rsp_ready;
   logic              can_accept;
   logic              gnt_valid;
   logic              gnt_port;
   logic [3:0]        alu_op;
   logic [XLEN-1:0]   alu_lhs, alu_rhs, alu_res;
   logic              rsp_hs;

   function automatic logic [XLEN-1:0] alu_f(input logic [3:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
      logic [SH_W-1:0] sh;
      sh = b[SH_W-1:0];
      case (op)
         ALU_OP_ADD:  alu_f = a + b;
         ALU_OP_SUB:  alu_f = a - b;
         ALU_OP_SLL:  alu_f = a << sh;
         ALU_OP_SLT:  alu_f = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_OP_SLTU: alu_f = {{(XLEN-1){1'b0}}, (a < b)};
         ALU_OP_XOR:  alu_f = a ^ b;
         ALU_OP_SRL:  alu_f = a >> sh;
         ALU_OP_SRA:  alu_f = $unsigned($signed(a) >>> sh);
         ALU_OP_OR:   alu_f = a | b;
         ALU_OP_AND:  alu_f = a & b;
         default:     alu_f = ALU_DFLT;
      endcase
   endfunction

   // Only the current owner's rsp_ready frees the slot; the other port's is ignored.
   assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;
   assign rsp_hs          = (state_q == RESP) && owner_rsp_ready;
   assign can_accept      = (state_q == IDLE) || rsp_hs;

   // Round-robin: on a tie the port that did not win last time is granted.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_port  = 1'b0;
      if (can_accept) begin
         if (req0_valid && req1_valid) begin
            gnt_valid = 1'b1;
            gnt_port  = ~last_grant_q;
         end else if (req0_valid) begin
            gnt_valid = 1'b1;
            gnt_port  = 1'b0;
         end else if (req1_valid) begin
            gnt_valid = 1'b1;
            gnt_port  = 1'b1;
         end
      end
   end

   assign alu_op  = gnt_port ? req1_op  : req0_op;
   assign alu_lhs = gnt_port ? req1_lhs : req0_lhs;
   assign alu_rhs = gnt_port ? req1_rhs : req0_rhs;
   assign alu_res = alu_f(alu_op, alu_lhs, alu_rhs);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (gnt_valid) state_d = RESP;
         RESP:    if (owner_rsp_ready && !gnt_valid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req0_ready = gnt_valid && !gnt_port;
      req1_ready = gnt_valid &&  gnt_port;
      rsp0_valid = (state_q == RESP) && !owner_q;
      rsp1_valid = (state_q == RESP) &&  owner_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_q        <= '0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
      end else begin
         if (gnt_valid) begin
            res_q        <= alu_res;
            owner_q      <= gnt_port;
            last_grant_q <= gnt_port;
         end
         if (rsp_hs) cnt_q <= cnt_q + CNT_ONE;
      end
   end

   assign rsp0_res  = res_q;
   assign rsp1_res  = res_q;
   assign ops_count = cnt_q;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one combinational alu instance between two requesters, e.g. the execute stage and a future address-generation or CSR path. It uses valid/ready request and response channels per port and round-robin arbitration. The result is registered and held until the owning port accepts it. Throughput is one operation per cycle when responses drain immediately.

Parameters:
- XLEN, 32, datapath width; must equal REG_END_WORD+1 from defs.vh.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  port 0 request valid.
- req0_ready  output  1  port 0 request accepted this cycle.
- req0_op  input  4  port 0 ALU_OP_* code from defs.vh.
- req0_lhs  input  XLEN  port 0 left operand.
- req0_rhs  input  XLEN  port 0 right operand.
- rsp0_valid  output  1  port 0 result valid.
- rsp0_ready  input  1  port 0 consumes result.
- rsp0_res  output  XLEN  port 0 result.
- req1_valid, req1_ready, req1_op, req1_lhs, req1_rhs, rsp1_valid, rsp1_ready, rsp1_res: same as port 0, for port 1.
- ops_count  output  CNT_W  number of completed response handshakes; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, rsp0_valid=rsp1_valid=0, res_q=0, owner_q=0.
  - last_grant=1, so port 0 wins the first tie.
  - ops_count=0.
- States:
  - IDLE: no result held.
  - RESP: res_q is valid for port owner_q.
- Slot free (can_accept): state==IDLE, or state==RESP with rsp_ready of owner_q high this cycle.
- Arbitration, combinational, only when can_accept:
  - Only one req_valid high: grant that port.
  - Both high: grant the port not equal to last_grant.
  - Neither high: no grant.
- req_ready:
  - reqN_ready=1 only for the granted port; at most one ready high per cycle.
  - Ready depends combinationally on valid and on rsp_ready; requesters must not make valid depend on ready.
- Datapath:
  - The granted port's op/lhs/rhs are muxed into the alu in the same cycle.
  - On the edge: res_q<=alu res, owner_q<=granted port, last_grant<=granted port, state<=RESP.
  - Latency: request handshake in cycle N, rsp valid in cycle N+1.
- Response outputs:
  - rspN_valid = (state==RESP && owner_q==N).
  - rsp0_res = rsp1_res = res_q; data is only meaningful while the matching valid is high.
  - While valid and ready is low, res_q and owner_q are held stable; no grants occur.
- RESP transitions:
  - Owner rsp_ready high with a grant: reload res_q, owner_q, last_grant; stay in RESP. There is no bubble.
  - Owner rsp_ready high with no grant: go to IDLE.
- ops_count increments by 1 on each response handshake (valid && ready); wraps from max to 0.
- Op codes pass through unchanged. An unimplemented op yields the alu default 32'h0000000A; it is not an error.
- A request held valid while not granted must keep its op and operands stable.
- Non-owner rsp_ready is ignored.

Test Plan:
- Single port: req0 ALU_OP_ADD lhs=5 rhs=7, rsp0_ready=1 -> req0_ready=1 in cycle N; rsp0_valid=1, rsp0_res=12 in N+1; rsp1_valid=0 throughout; ops_count=1.
- Tie after reset: both valid in the same cycle; port 0 ALU_OP_SUB 10,3; port 1 ALU_OP_SLT 32'hFFFFFFFF,1.
  - Port 0 is granted first -> res 7.
  - Port 1 is granted next cycle -> res 1.
  - With both held continuously valid, grants alternate 0,1,0,1.
- Backpressure: rsp0_ready=0 for 3 cycles after ALU_OP_SLL 1,4 -> rsp0_valid=1, res=16 stable; req0_ready=req1_ready=0 while req1_valid=1; grant to port 1 in the cycle rsp0_ready rises.
- Back-to-back: rsp0 handshake in the same cycle as req1 ALU_OP_SRA 32'h80000000,4 -> next cycle rsp1_valid=1, res=32'hF8000000; no IDLE cycle.
- Reset mid-operation: assert reset while in RESP with rsp1_valid=1 -> rsp1_valid=0 and ops_count=0 before the next clock edge; after release, a tie grants port 0.
- Unimplemented op 4'hF, lhs=1, rhs=2 -> rsp_res=32'h0000000A.
- Counter wrap: force 2^16 handshakes -> ops_count wraps to 0.
